waterfall_sequencer: RTL and testbench

- Controller that sequences the normalized fall-time value t feeding the squaring/LED datapath of the waterfall display.
- Replaces the free-running up/down counter with an explicit state machine: start, fall, hold at bottom, optional rise (bounce), hold at top, and repeat or stop.
- Sits between the board clock/reset and the t**2 multiplier stage; the downstream datapath consumes t and t_valid unchanged.

---
 rtl/waterfall_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/waterfall_sequencer.sv | 138 +++++++++++++
 tb/tb_waterfall_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waterfall_pkg.sv
// Shared types and default constants for the waterfall display sequencer.
// phase_t is exported on the phase port, so its encoding is fixed.
package waterfall_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FALL     = 3'd1,
        HOLD_BOT = 3'd2,
        RISE     = 3'd3,
        HOLD_TOP = 3'd4
    } phase_t;

    localparam int T_BITS_DEF     = 17;
    localparam int TICK_DIV_DEF   = 381;
    localparam int HOLD_TICKS_DEF = 4096;

endpackage

// File: rtl/tick_prescaler.sv
// Mod-M time-base counter. It is enabled externally, and a synchronous clear overrides the enable.
// tick is combinational and goes high during the last count of each period.
module tick_prescaler #(
    parameter int M = 381
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/waterfall_sequencer.sv
// Sequences the normalized fall time t through the cycle fall / bottom hold / optional rise / top hold.
// t, t_valid, phase, busy and seq_done are all registered. t_valid and seq_done are one-clock strobes.
module waterfall_sequencer
    import waterfall_pkg::*;
#(
    parameter int T_BITS     = T_BITS_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              start,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              bounce_en,
    output logic [T_BITS-1:0] t,
    output logic              t_valid,
    output phase_t            phase,
    output logic              busy,
    output logic              seq_done
);

    localparam logic [T_BITS-1:0] T_MAX     = '1;
    localparam int                HC_W      = $clog2(HOLD_TICKS + 1);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_TICKS - 1);

    phase_t            state_d;
    logic [T_BITS-1:0] t_d;
    logic              t_valid_d;
    logic              seq_done_d;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_d;
    logic              tick;
    logic              pres_en;
    logic              pres_clr;

    // The time base runs only while a sequence is active and not paused. It restarts on every state entry.
    assign pres_en  = (phase != IDLE) && !pause;
    assign pres_clr = (state_d != phase);

    tick_prescaler #(
        .M (TICK_DIV)
    ) u_prescaler (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .en    (pres_en),
        .clr   (pres_clr),
        .tick  (tick)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            phase    <= IDLE;
            t        <= '0;
            t_valid  <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
            hold_cnt <= '0;
        end else begin
            phase    <= state_d;
            t        <= t_d;
            t_valid  <= t_valid_d;
            busy     <= (state_d != IDLE);
            seq_done <= seq_done_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d    = phase;
        t_d        = t;
        t_valid_d  = 1'b0;
        seq_done_d = 1'b0;
        hold_d     = hold_cnt;
        if (!pause) begin
            unique case (phase)
                IDLE: begin
                    if (start) begin
                        t_d       = '0;
                        t_valid_d = 1'b1;
                        state_d   = FALL;
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (t != T_MAX) begin
                            t_d       = t + 1'b1;
                            t_valid_d = 1'b1;
                        end else begin
                            state_d = HOLD_BOT;
                        end
                    end
                end
                // Mode bits are sampled only here, so changes mid-sequence wait for a boundary.
                HOLD_BOT: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_d = '0;
                            if (bounce_en) begin
                                state_d = RISE;
                            end else begin
                                t_d        = '0;
                                t_valid_d  = 1'b1;
                                seq_done_d = 1'b1;
                                state_d    = loop_en ? FALL : IDLE;
                            end
                        end else begin
                            hold_d = hold_cnt + 1'b1;
                        end
                    end
                end
                RISE: begin
                    if (tick) begin
                        if (t != '0) begin
                            t_d       = t - 1'b1;
                            t_valid_d = 1'b1;
                        end else begin
                            state_d = HOLD_TOP;
                        end
                    end
                end
                HOLD_TOP: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_d     = '0;
                            seq_done_d = 1'b1;
                            state_d    = loop_en ? FALL : IDLE;
                        end else begin
                            hold_d = hold_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_waterfall_sequencer.sv
// Self-checking bench for waterfall_sequencer: directed scenarios plus random stimulus against a
// segment/tick-count reference model.
module tb_waterfall_sequencer;

    localparam int T_BITS     = 4;
    localparam int TICK_DIV   = 3;
    localparam int HOLD_TICKS = 2;
    localparam int T_MAX      = (1 << T_BITS) - 1;

    localparam int P_IDLE     = 0;
    localparam int P_FALL     = 1;
    localparam int P_HOLD_BOT = 2;
    localparam int P_RISE     = 3;
    localparam int P_HOLD_TOP = 4;

    localparam int SPAN_SINGLE = (T_MAX + 1 + HOLD_TICKS) * TICK_DIV;
    localparam int SPAN_BOUNCE = (1 + T_MAX + HOLD_TICKS + T_MAX + 1 + HOLD_TICKS) * TICK_DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic              bounce_en = 1'b0;
    logic [T_BITS-1:0] t;
    logic              t_valid;
    logic [2:0]        phase;
    logic              busy;
    logic              seq_done;

    waterfall_sequencer #(
        .T_BITS     (T_BITS),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .start      (start),
        .pause      (pause),
        .loop_en    (loop_en),
        .bounce_en  (bounce_en),
        .t          (t),
        .t_valid    (t_valid),
        .phase      (phase),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: current segment, ticks elapsed in it, clocks elapsed toward the next tick.
    int   m_phase = P_IDLE;
    int   m_t     = 0;
    int   m_k     = 0;
    int   m_clk   = 0;
    logic exp_valid = 1'b0;
    logic exp_done  = 1'b0;
    logic [T_BITS-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_enter(input int ph);
        m_phase = ph;
        m_k     = 0;
        m_clk   = 0;
    endtask

    task automatic model_reset();
        model_enter(P_IDLE);
        m_t       = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic s, input logic p, input logic l, input logic b);
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (p) return;
        if (m_phase == P_IDLE) begin
            if (s) begin
                m_t       = 0;
                exp_valid = 1'b1;
                model_enter(P_FALL);
            end
        end else begin
            m_clk++;
            if (m_clk == TICK_DIV) begin
                m_clk = 0;
                m_k++;
                case (m_phase)
                    P_FALL: begin
                        if (m_k <= T_MAX) begin
                            m_t = m_k;
                            exp_valid = 1'b1;
                        end else model_enter(P_HOLD_BOT);
                    end
                    P_RISE: begin
                        if (m_k <= T_MAX) begin
                            m_t = T_MAX - m_k;
                            exp_valid = 1'b1;
                        end else model_enter(P_HOLD_TOP);
                    end
                    P_HOLD_BOT: begin
                        if (m_k == HOLD_TICKS) begin
                            if (b) model_enter(P_RISE);
                            else begin
                                m_t       = 0;
                                exp_valid = 1'b1;
                                exp_done  = 1'b1;
                                model_enter(l ? P_FALL : P_IDLE);
                            end
                        end
                    end
                    P_HOLD_TOP: begin
                        if (m_k == HOLD_TICKS) begin
                            exp_done = 1'b1;
                            model_enter(l ? P_FALL : P_IDLE);
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (exp_valid) exp_q.push_back(T_BITS'(m_t));
    endtask

    task automatic compare_outputs();
        check("phase", 32'(phase), 32'(m_phase));
        check("busy", 32'(busy), 32'(m_phase != P_IDLE));
        check("t_valid", 32'(t_valid), 32'(exp_valid));
        check("seq_done", 32'(seq_done), 32'(exp_done));
        check("t", 32'(t), 32'(m_t));
        if (t_valid) begin
            if (exp_q.size() == 0) check("strobe_unexpected", 32'(1), 32'(0));
            else check("strobe_t", 32'(t), 32'(exp_q.pop_front()));
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
    task automatic cycle(input logic s, input logic p, input logic l, input logic b);
        @(negedge clk);
        rst_n     = 1'b1;
        start     = s;
        pause     = p;
        loop_en   = l;
        bounce_en = b;
        @(posedge clk);
        model_step(s, p, l, b);
        #1;
        compare_outputs();
    endtask

    // Asserts reset between clock edges and checks that the outputs clear without waiting for a clock.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_t", 32'(t), 32'(0));
        check("rst_phase", 32'(phase), 32'(P_IDLE));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_valid", 32'(t_valid), 32'(0));
        check("rst_done", 32'(seq_done), 32'(0));
        model_reset();
    endtask

    task automatic run_to_idle(input logic s, input logic l, input logic b,
                               output int span, output int n_valid, output int n_done);
        span = 0;
        n_valid = 0;
        n_done = 0;
        do begin
            cycle(s, 1'b0, l, b);
            span++;
            if (t_valid) n_valid++;
            if (seq_done) n_done++;
        end while (busy && span < 1000);
        if (busy) check("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic run_to_t(input int tv, input int ph, input logic l, input logic b);
        int n = 0;
        while (!(t == T_BITS'(tv) && phase == 3'(ph)) && n < 400) begin
            cycle(1'b0, 1'b0, l, b);
            n++;
        end
        check("reach_t_timeout", 32'(n < 400), 32'(1));
    endtask

    initial begin
        int span, n_valid, n_done, lat;
        logic any_idle;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_t", 32'(t), 32'(0));
        check("reset_phase", 32'(phase), 32'(P_IDLE));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_valid", 32'(t_valid), 32'(0));
        check("reset_done", 32'(seq_done), 32'(0));

        // Single sequence without bounce; start held high throughout to show it is ignored when busy.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_load_valid", 32'(t_valid), 32'(1));
        run_to_idle(1'b1, 1'b0, 1'b0, span, n_valid, n_done);
        check("single_span", 32'(span), 32'(SPAN_SINGLE));
        check("single_strobes", 32'(n_valid), 32'(T_MAX + 1));
        check("single_done", 32'(n_done), 32'(1));
        check("single_end_t", 32'(t), 32'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce, single sequence.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_to_idle(1'b0, 1'b0, 1'b1, span, n_valid, n_done);
        check("bounce_span", 32'(span), 32'(SPAN_BOUNCE));
        check("bounce_strobes", 32'(n_valid), 32'(2 * T_MAX));
        check("bounce_done", 32'(n_done), 32'(1));

        // Looping without bounce: three sequences back to back with no idle gap.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        n_done = 0;
        any_idle = 1'b0;
        for (int i = 0; i < 3 * SPAN_SINGLE; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (seq_done) n_done++;
            if (!busy) any_idle = 1'b1;
        end
        check("loop_done_count", 32'(n_done), 32'(3));
        check("loop_no_idle", 32'(any_idle), 32'(0));
        check("loop_phase_fall", 32'(phase), 32'(P_FALL));
        run_to_idle(1'b0, 1'b0, 1'b0, span, n_valid, n_done);

        // Pause for 10 clocks at t = 7, one clock into the tick period.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_to_t(7, P_FALL, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check("pause_t", 32'(t), 32'(7));
            check("pause_valid", 32'(t_valid), 32'(0));
        end
        lat = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            lat++;
        end while (!t_valid && lat < 10);
        check("pause_resume_latency", 32'(lat), 32'(TICK_DIV - 1));
        check("pause_resume_t", 32'(t), 32'(8));
        run_to_idle(1'b0, 1'b0, 1'b0, span, n_valid, n_done);

        // Reset during RISE at t = 9, then a fresh sequence.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_to_t(9, P_RISE, 1'b0, 1'b1);
        reset_pulse();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("post_reset_no_done", 32'(seq_done), 32'(0));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("fresh_fall_phase", 32'(phase), 32'(P_FALL));
        run_to_idle(1'b0, 1'b0, 1'b0, span, n_valid, n_done);
        check("fresh_span", 32'(span), 32'(SPAN_SINGLE));

        // start together with pause in IDLE must be ignored.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            check("start_pause_idle", 32'(phase), 32'(P_IDLE));
        end

        // Random stimulus with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) reset_pulse();
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 99) < 50) ? loop_en ^ 1'($urandom_range(0, 40) == 0) : loop_en,
                  bounce_en ^ 1'($urandom_range(0, 60) == 0));
        end
        run_to_idle(1'b0, 1'b0, bounce_en, span, n_valid, n_done);
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
